// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative multiply/divide sequencer.
//   state_e       : sequencer states (IDLE, RUN, FIX, DONE)
//   op_e          : operation encodings (OP_MULT = 0, OP_DIV = 1)
//   WIDTH_DEFAULT : default operand/result width
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/result bundle between the CPU control unit
// and the multiply/divide sequencer.
//   start, op, a, b        : request from the control unit (master)
//   busy, done             : sequencing status from the unit (slave)
//   hi_lo_write, hi, lo    : result write strobe and HI/LO values
//   div_zero               : divide-by-zero exception pulse
// Modports: master = control unit side, slave = sequencer side.
interface muldiv_sequencer_if #(
  parameter int WIDTH = muldiv_pkg::WIDTH_DEFAULT
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             hi_lo_write;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi_lo_write, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi_lo_write, hi, lo, div_zero
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: combinational single-iteration datapath for the sequencer.
//   op       : OP_MULT = shift-add step, OP_DIV = restoring-division step
//   acc      : current accumulator, 2*WIDTH+1 bits
//              mult: {partial product (WIDTH+1), remaining multiplier (WIDTH)}
//              div : {partial remainder (WIDTH+1), dividend/quotient (WIDTH)}
//   mag      : operand magnitude (multiplicand or divisor), WIDTH+1 bits
//   acc_next : accumulator after one iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             op,
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH:0]   mag,
  output logic [2*WIDTH:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] shl;

  always_comb begin
    sum      = '0;
    diff     = '0;
    shl      = '0;
    acc_next = acc;
    if (op == OP_MULT) begin
      // Add multiplicand when the current multiplier LSB is set, then shift
      // the whole accumulator right; the sum LSB drops into the product half.
      sum      = acc[2*WIDTH:WIDTH] + (acc[0] ? mag : '0);
      acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    end else begin
      // Shift next dividend bit into the remainder, subtract if it fits.
      shl  = {acc[2*WIDTH-1:0], 1'b0};
      diff = shl[2*WIDTH:WIDTH] - mag;
      if (shl[2*WIDTH:WIDTH] >= mag) begin
        acc_next = {diff, shl[WIDTH-1:1], 1'b1};
      end else begin
        acc_next = shl;
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply/divide unit for the HI/LO path.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : muldiv_sequencer_if.slave (start/op/a/b in; busy/done/
//           hi_lo_write/hi/lo/div_zero out)
// Operation: start in IDLE latches signs and magnitudes, RUN performs WIDTH
// iterations through muldiv_step, FIX applies signs and registers HI/LO,
// DONE pulses done (and hi_lo_write or div_zero).
// Optional macro MULDIV_FAST_MULT_EN: multiply completes with a single-cycle
// multiplier, going IDLE -> DONE; divide timing is unchanged.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;
  logic               sign_a, sign_b;
  logic               dz_q;
  logic [WIDTH:0]     mag;
  logic [2*WIDTH:0]   acc, acc_next;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH:0]     mag_a_in, mag_b_in;
  logic               b_zero, accept, last_iter;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed, rem_signed;
`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
`endif

  // Magnitude in WIDTH+1 bits so that |-2^(WIDTH-1)| is representable.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return ext[WIDTH] ? (~ext + (WIDTH+1)'(1)) : ext;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(
      input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign mag_a_in  = magnitude(bus.a);
  assign mag_b_in  = magnitude(bus.b);
  assign b_zero    = (bus.b == '0);
  assign accept    = (state == IDLE) && bus.start;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Sign fix-up of the finished unsigned result; remainder follows dividend.
  assign prod_signed = apply_sign_wide(acc[2*WIDTH-1:0], sign_a ^ sign_b);
  assign quot_signed = apply_sign(acc[WIDTH-1:0], sign_a ^ sign_b);
  assign rem_signed  = apply_sign(acc[2*WIDTH-1:WIDTH], sign_a);

`ifdef MULDIV_FAST_MULT_EN
  // Sign-extended operands: the low 2*WIDTH bits of their product are the
  // exact signed product.
  assign fast_a    = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign fast_b    = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign fast_prod = fast_a * fast_b;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_q),
    .acc      (acc),
    .mag      (mag),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
    bus.hi_lo_write = (state == DONE) && !dz_q;
    bus.div_zero    = (state == DONE) && dz_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if ((bus.op == OP_DIV) && b_zero) begin
            state_next = DONE;
`ifdef MULDIV_FAST_MULT_EN
          end else if (bus.op == OP_MULT) begin
            state_next = DONE;
`endif
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control and architectural result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept) begin
        cnt  <= '0;
        dz_q <= (bus.op == OP_DIV) && b_zero;
`ifdef MULDIV_FAST_MULT_EN
        if (bus.op == OP_MULT) begin
          hi_q <= fast_prod[2*WIDTH-1:WIDTH];
          lo_q <= fast_prod[WIDTH-1:0];
        end
`endif
      end else if (state == RUN) begin
        cnt <= cnt + CNT_W'(1);
      end else if (state == FIX) begin
        if (op_q == OP_MULT) begin
          hi_q <= prod_signed[2*WIDTH-1:WIDTH];
          lo_q <= prod_signed[WIDTH-1:0];
        end else begin
          hi_q <= rem_signed;
          lo_q <= quot_signed;
        end
      end
    end
  end

  // Iteration datapath; only meaningful while RUN/FIX, so left unreset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= bus.op;
      sign_a <= bus.a[WIDTH-1];
      sign_b <= bus.b[WIDTH-1];
      if (bus.op == OP_MULT) begin
        mag <= mag_a_in;
        acc <= {{(WIDTH+1){1'b0}}, mag_b_in[WIDTH-1:0]};
      end else begin
        mag <= mag_b_in;
        acc <= {{(WIDTH+1){1'b0}}, mag_a_in[WIDTH-1:0]};
      end
    end else if (state == RUN) begin
      acc <= acc_next;
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer
// (32-bit). Honours MULDIV_FAST_MULT_EN for expected multiply timing.
module tb_muldiv_sequencer;

  localparam logic OPM = 1'b0;
  localparam logic OPD = 1'b1;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MULT_LAT  = 0;
  localparam int MULT_BUSY = 1;
`else
  localparam int MULT_LAT  = 33;
  localparam int MULT_BUSY = 34;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, then watch 40 cycles. Optionally pulse a second
  // start at sample start_k (must be ignored by a busy unit).
  task automatic run_op(input logic op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input int start_k,
                        output int lat, output int busy_n, output int done_n,
                        output logic [31:0] hi_o, output logic [31:0] lo_o,
                        output logic hlw_o, output logic dz_o);
    bus.start = 1'b1; bus.op = op_i; bus.a = a_i; bus.b = b_i;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1; busy_n = 0; done_n = 0;
    hi_o = '0; lo_o = '0; hlw_o = 1'b0; dz_o = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (lat < 0) begin
          lat = k; hi_o = bus.hi; lo_o = bus.lo;
          hlw_o = bus.hi_lo_write; dz_o = bus.div_zero;
        end
      end
      if (k == start_k) begin
        bus.start = 1'b1; bus.op = OPD; bus.a = 32'd100; bus.b = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic op_i,
                          input logic [31:0] a_i, input logic [31:0] b_i,
                          input int start_k, input int exp_lat,
                          input int exp_busy, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
    int lat, busy_n, done_n;
    logic [31:0] hi_o, lo_o;
    logic hlw_o, dz_o;
    run_op(op_i, a_i, b_i, start_k, lat, busy_n, done_n, hi_o, lo_o, hlw_o, dz_o);
    chk({tag, "_lat"},    64'(lat),    64'(exp_lat));
    chk({tag, "_busy"},   64'(busy_n), 64'(exp_busy));
    chk({tag, "_ndone"},  64'(done_n), 64'd1);
    chk({tag, "_hi"},     64'(hi_o),   64'(exp_hi));
    chk({tag, "_lo"},     64'(lo_o),   64'(exp_lo));
    chk({tag, "_hlw"},    64'(hlw_o),  64'(!exp_dz));
    chk({tag, "_dz"},     64'(dz_o),   64'(exp_dz));
    chk({tag, "_hihold"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, "_lohold"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    int done_n;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = OPM; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hlw",  64'(bus.hi_lo_write), 64'd0);
    chk("rst_dz",   64'(bus.div_zero), 64'd0);
    chk("rst_hi",   64'(bus.hi), 64'd0);
    chk("rst_lo",   64'(bus.lo), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    check_op("mul_7_m3", OPM, 32'd7, 32'hFFFFFFFD, -1, MULT_LAT, MULT_BUSY,
             32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    check_op("div_m7_2", OPD, 32'hFFFFFFF9, 32'd2, -1, 33, 34,
             32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    // Divide-by-zero keeps the previous HI/LO.
    check_op("div_5_0", OPD, 32'd5, 32'd0, -1, 0, 1,
             32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    check_op("mul_min_min", OPM, 32'h80000000, 32'h80000000, -1, MULT_LAT,
             MULT_BUSY, 32'h40000000, 32'h00000000, 1'b0);
    check_op("div_min_m1", OPD, 32'h80000000, 32'hFFFFFFFF, -1, 33, 34,
             32'h00000000, 32'h80000000, 1'b0);
    check_op("div_7_m2", OPD, 32'd7, 32'hFFFFFFFE, -1, 33, 34,
             32'h00000001, 32'hFFFFFFFD, 1'b0);
    check_op("mul_m5_m6", OPM, 32'hFFFFFFFB, 32'hFFFFFFFA, -1, MULT_LAT,
             MULT_BUSY, 32'h00000000, 32'h0000001E, 1'b0);
    // Second start during a running divide must be ignored.
    check_op("div_ign", OPD, 32'd100, 32'd7, 10, 33, 34,
             32'h00000002, 32'h0000000E, 1'b0);

    // Reset in the middle of a divide.
    bus.start = 1'b1; bus.op = OPD; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) done_n++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_busy", 64'(bus.busy), 64'd0);
    chk("mid_done", 64'(bus.done), 64'd0);
    chk("mid_hlw",  64'(bus.hi_lo_write), 64'd0);
    chk("mid_dz",   64'(bus.div_zero), 64'd0);
    chk("mid_hi",   64'(bus.hi), 64'd0);
    chk("mid_lo",   64'(bus.lo), 64'd0);
    for (int k = 0; k < 40; k++) begin
      if (bus.done) done_n++;
      @(posedge clk); #1;
    end
    chk("mid_nodone", 64'(done_n), 64'd0);
    check_op("mul_9_9", OPM, 32'd9, 32'd9, -1, MULT_LAT, MULT_BUSY,
             32'h00000000, 32'h00000051, 1'b0);
    check_op("mul_fast", OPM, 32'h12345678, 32'h00000010, -1, MULT_LAT,
             MULT_BUSY, 32'h00000001, 32'h23456780, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
